// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between MEM and a word-wide,
// byte-addressed data memory. Byte/half/word loads with sign or zero
// extension; sub-word stores use read-modify-write.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned requests answer
// with rsp_err instead of being silently aligned to the natural boundary).
//
// state | meaning
// IDLE  | ready for a request; response of the previous one is visible
// RD    | memory word being read (load result, or merge for sub-word store)
// WR    | memory write cycle (word store data or merged word)
// ERR   | misaligned request being answered with rsp_err (macro only)
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
`endif

  state_t      state, state_d;
  logic [31:0] addr_q, wdata_q, merge_q, merge_d;
  logic [1:0]  size_q;
  logic        we_q, uns_q;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic        accept;
  logic        req_is_word, req_is_half;
  logic [31:0] req_addr_eff;
  logic        is_word, is_half;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data, merged;

  assign accept      = req_valid & req_ready;
  assign req_is_word = req_size[1];
  assign req_is_half = (req_size == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misaligned;
  logic rsp_err_q, rsp_err_d;
  assign req_misaligned = (req_is_half & req_addr[0]) | (req_is_word & (|req_addr[1:0]));
  assign req_addr_eff   = req_addr;
  assign rsp_err        = rsp_err_q;
`else
  // Misaligned accesses fold down to the natural boundary of their size.
  assign req_addr_eff = req_is_word ? {req_addr[31:2], 2'b00} :
                        req_is_half ? {req_addr[31:1], 1'b0}  : req_addr;
  assign rsp_err      = 1'b0;
`endif

  assign is_word = size_q[1];
  assign is_half = ~size_q[1] & size_q[0];

  assign req_ready = (state == IDLE);
  assign mem_A     = {addr_q[31:2], 2'b00};
  assign mem_WE    = (state == WR) & ~rst;
  assign mem_WD    = (state == WR) ? (is_word ? wdata_q : merge_q) : 32'd0;

  // Little-endian lane selection and load extension
  always_comb begin
    byte_lane = mem_RD[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    if (is_word)
      load_data = mem_RD;
    else if (is_half)
      load_data = {{16{~uns_q & half_lane[15]}}, half_lane};
    else
      load_data = {{24{~uns_q & byte_lane[7]}}, byte_lane};
  end

  // Merge store data into the addressed lane of the word just read
  always_comb begin
    merged = mem_RD;
    if (is_half) begin
      if (addr_q[1])
        merged[31:16] = wdata_q[15:0];
      else
        merged[15:0] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next state and next response values
  always_comb begin
    state_d     = state;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    merge_d     = merge_q;
`ifdef LSU_MISALIGN_TRAP_EN
    rsp_err_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_we && req_is_word)
            state_d = WR;
          else
            state_d = RD;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_misaligned)
            state_d = ERR;
`endif
        end
      end
      RD: begin
        if (we_q) begin
          merge_d = merged;
          state_d = WR;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          state_d     = IDLE;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Request capture, merge buffer and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 32'd0;
      merge_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= req_addr_eff;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      merge_q   <= merge_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written reset
// and back-to-back sequences, then random requests against a byte-level
// reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT: 16 words, preloaded while init_mem is high
  logic [31:0] mem [16];
  logic [31:0] init_img [16];
  logic        init_mem;
  int          wr_cnt = 0;

  assign mem_RD = mem[mem_A[5:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
    end else if (mem_WE) begin
      mem[mem_A[5:2]] <= mem_WD;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Reference memory, byte granular
  logic [7:0] ref_mem [64];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Reference behaviour: what a request does to memory and what it answers
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input int addr, input logic [31:0] wdata,
                       output logic [31:0] e_rdata, output logic e_err,
                       output int e_lat, output int e_wec, output logic [31:0] e_wd);
    int nb, base;
    logic [31:0] v;
    logic trap;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_rdata = 0; e_err = 0; e_wec = 0; e_wd = 0; e_lat = 1;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (addr % nb) != 0;
`endif
    base = addr - (addr % nb);
    if (trap) begin
      e_err = 1'b1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
      if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      e_rdata = v;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[base+i] = wdata[8*i +: 8];
      e_wec = 1;
      e_lat = (nb == 4) ? 1 : 2;
      e_wd  = ref_word(base - (base % 4));
    end
  endtask

  // Issue one request from IDLE and observe it until its response
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int busy, output int wec, output logic [31:0] wd);
    @(negedge clk);
    chk("pulse rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; busy = 0; wec = 0; wd = 0; rdata = 0; err = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      if (mem_WE) begin wec++; wd = mem_WD; end
      if (!req_ready) busy++;
      @(negedge clk);
      if (rsp_valid) begin lat = n; rdata = rsp_rdata; err = rsp_err; end
    end
  endtask

  task automatic run_and_check(input string name, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                               input int e_wec, input logic [31:0] e_wd);
    logic [31:0] rdata, wd;
    logic err;
    int lat, busy, wec;
    do_req(we, size, uns, addr, wdata, rdata, err, lat, busy, wec, wd);
    chk($sformatf("%s latency", name), lat, e_lat);
    chk($sformatf("%s rdata", name), rdata, e_rdata);
    chk($sformatf("%s err", name), {31'd0, err}, {31'd0, e_err});
    chk($sformatf("%s busy", name), busy, e_lat);
    chk($sformatf("%s we_cycles", name), wec, e_wec);
    if (e_wec != 0) chk($sformatf("%s mem_WD", name), wd, e_wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
    int          e_wec;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] e_rdata, logic e_err,
                              int e_lat, int e_wec, logic [31:0] e_wd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat; v.e_wec = e_wec; v.e_wd = e_wd;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    logic [31:0] m_rdata, m_wd;
    logic        m_err;
    int          m_lat, m_wec, w0, acc;

    tbl[0]  = mk(0, 2'd2, 0, 32'h10, 32'h0,        32'h8899AABB, 0, 1, 0, 32'h0);
    tbl[1]  = mk(0, 2'd0, 0, 32'h12, 32'h0,        32'hFFFFFF99, 0, 1, 0, 32'h0);
    tbl[2]  = mk(0, 2'd0, 1, 32'h12, 32'h0,        32'h00000099, 0, 1, 0, 32'h0);
    tbl[3]  = mk(0, 2'd1, 0, 32'h12, 32'h0,        32'hFFFF8899, 0, 1, 0, 32'h0);
    tbl[4]  = mk(0, 2'd1, 1, 32'h10, 32'h0,        32'h0000AABB, 0, 1, 0, 32'h0);
    tbl[5]  = mk(1, 2'd0, 0, 32'h11, 32'h123456CC, 32'h0,        0, 2, 1, 32'h8899CCBB);
    tbl[6]  = mk(0, 2'd2, 0, 32'h10, 32'h0,        32'h8899CCBB, 0, 1, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[7]  = mk(0, 2'd1, 0, 32'h13, 32'h0,        32'h0,        1, 1, 0, 32'h0);
`else
    tbl[7]  = mk(0, 2'd1, 0, 32'h13, 32'h0,        32'hFFFF8899, 0, 1, 0, 32'h0);
`endif
    tbl[8]  = mk(1, 2'd2, 0, 32'h14, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'hDEADBEEF);
    tbl[9]  = mk(1, 2'd1, 0, 32'h16, 32'hCAFE1234, 32'h0,        0, 2, 1, 32'h1234BEEF);
    tbl[10] = mk(0, 2'd3, 1, 32'h14, 32'h0,        32'h1234BEEF, 0, 1, 0, 32'h0);
    tbl[11] = mk(0, 2'd0, 0, 32'h15, 32'h0,        32'hFFFFFFBE, 0, 1, 0, 32'h0);
    tbl[12] = mk(0, 2'd1, 0, 32'h16, 32'h0,        32'h00001234, 0, 1, 0, 32'h0);
    tbl[13] = mk(0, 2'd0, 1, 32'h17, 32'h0,        32'h00000012, 0, 1, 0, 32'h0);

    for (int i = 0; i < 16; i++) init_img[i] = $urandom;
    init_img[4] = 32'h8899AABB;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_img[i/4][8*(i%4) +: 8];

    // Reset held for two cycles while a request is offered
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset mem_WE", {31'd0, mem_WE}, 32'd0);
      chk("reset mem_A", mem_A, 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
    end
    rst = 1'b0; init_mem = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post-reset mem_WD", mem_WD, 32'd0);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, int'(tbl[i].addr), tbl[i].wdata,
            m_rdata, m_err, m_lat, m_wec, m_wd);
      run_and_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns,
                    tbl[i].addr, tbl[i].wdata, tbl[i].e_rdata, tbl[i].e_err,
                    tbl[i].e_lat, tbl[i].e_wec, tbl[i].e_wd);
    end

    // Back-to-back loads: request held valid, accepted every second cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; acc = 0;
    for (int i = 0; i < 10; i++) begin
      chk("b2b req_ready", {31'd0, req_ready}, {31'd0, (i % 2) == 0});
      chk("b2b rsp_valid", {31'd0, rsp_valid}, {31'd0, (i > 0) && ((i % 2) == 0)});
      if (rsp_valid) chk("b2b rdata", rsp_rdata, 32'h8899CCBB);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b last rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b last rdata", rsp_rdata, 32'h8899CCBB);
    chk("b2b accepts", acc, 5);

    // Sub-word store with reset landing on its write cycle
    @(negedge clk);
    chk("rstwr idle req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h00007777;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwr mem_WE", {31'd0, mem_WE}, 32'd0);
    @(negedge clk);
    chk("rstwr rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwr rsp_valid after", {31'd0, rsp_valid}, 32'd0);
    chk("rstwr write count", wr_cnt, w0);
    run_and_check("rstwr reload", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,
                  32'h8899CCBB, 1'b0, 1, 0, 32'h0);

    // Random requests against the reference memory
    for (int i = 0; i < 150; i++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;
      r_we = 1'($urandom); r_uns = 1'($urandom); r_size = 2'($urandom);
      r_addr = $urandom_range(0, 63); r_wdata = $urandom;
      model(r_we, r_size, r_uns, int'(r_addr), r_wdata, m_rdata, m_err, m_lat, m_wec, m_wd);
      run_and_check($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, r_wdata,
                    m_rdata, m_err, m_lat, m_wec, m_wd);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++)
      chk($sformatf("final mem word %0d", i), mem[i], ref_word(4*i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
